// File: rtl/omp_pkg.sv
// Shared constants and types for the OMP result reader: memory geometry,
// scan-state encoding and the (index, value) beat carried through the output buffer.
package omp_pkg;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int FIFO_D = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } omp_rd_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] index;
        logic [DATA_W-1:0] value;
    } omp_beat_t;

    localparam int BEAT_W = $bits(omp_beat_t);

endpackage

// File: rtl/omp_sync_fifo.sv
// Small synchronous FIFO with the head entry presented from storage registers,
// so the read side has no combinational path from the pop request.
module omp_sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Stale storage stays hidden behind zeros whenever the buffer is empty.
    assign o_valid = (r_count != '0);
    assign o_rdata = o_valid ? r_mem[r_rptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/omp_result_reader.sv
// Scans the sparse coefficient memory after the reconstruction core finishes and
// streams the nonzero (index, value) pairs to the result sink over valid/ready.
module omp_result_reader
    import omp_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_finish_flag,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_rd_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_out_index,
    output logic [DATA_W-1:0] o_out_value,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W:0]   o_nz_count
);

    localparam int CNT_W = $clog2(FIFO_D) + 1;

    omp_rd_state_t     r_state;
    omp_rd_state_t     w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_tag_valid;
    logic [ADDR_W-1:0] r_tag_addr;
    logic [ADDR_W:0]   r_nz_count;

    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_valid;
    logic [CNT_W:0]    w_occupancy;
    logic              w_credit_ok;
    logic              w_issue;
    logic              w_start;
    logic              w_push;
    logic              w_pop;
    omp_beat_t         w_push_beat;
    omp_beat_t         w_head_beat;

    // Buffered beats plus the read still in flight must leave room for its return.
    assign w_occupancy = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, r_tag_valid};
    assign w_credit_ok = (w_occupancy < (CNT_W + 1)'(FIFO_D));
    assign w_start     = (r_state == ST_IDLE) && i_finish_flag;

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        o_busy       = (r_state != ST_IDLE);
        o_done       = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE: begin
                if (i_finish_flag) begin
                    w_next_state = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_issue = w_credit_ok;
                if (w_credit_ok && (r_addr == ADDR_W'(DEPTH - 1))) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_tag_valid && (w_fifo_count == '0)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The tag register remembers which address the returning read data belongs to.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr      <= '0;
            r_tag_valid <= 1'b0;
            r_tag_addr  <= '0;
        end else begin
            if (w_start) begin
                r_addr <= '0;
            end else if (w_issue) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            r_tag_valid <= w_issue;
            r_tag_addr  <= r_addr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_nz_count <= '0;
        end else if (w_start) begin
            r_nz_count <= '0;
        end else if (w_pop) begin
            r_nz_count <= r_nz_count + (ADDR_W + 1)'(1);
        end
    end

    assign w_push      = r_tag_valid && (i_mem_rd_data != '0);
    assign w_push_beat = '{index: r_tag_addr, value: i_mem_rd_data};
    assign w_pop       = w_fifo_valid && i_out_ready;

    omp_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_wdata (w_push_beat),
        .i_pop   (w_pop),
        .o_valid (w_fifo_valid),
        .o_rdata (w_head_beat),
        .o_count (w_fifo_count)
    );

    assign o_mem_rd_en = w_issue;
    assign o_mem_addr  = r_addr;
    assign o_out_valid = w_fifo_valid;
    assign o_out_index = w_head_beat.index;
    assign o_out_value = w_head_beat.value;
    assign o_nz_count  = r_nz_count;

endmodule

// File: tb/tb_omp_result_reader.sv
// Directed bench for omp_result_reader: behavioural read memory, negedge monitor
// recording reads/beats/done pulses, and one task per scenario with inline checks.
module tb_omp_result_reader;
    import omp_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              finish = 1'b0;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] out_index;
    logic [DATA_W-1:0] out_value;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   nz;

    int n_compared = 0;
    int n_mismatched = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    omp_result_reader dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_finish_flag (finish),
        .o_mem_rd_en   (rd_en),
        .o_mem_addr    (addr),
        .i_mem_rd_data (rd_data),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_index   (out_index),
        .o_out_value   (out_value),
        .o_busy        (busy),
        .o_done        (done),
        .o_nz_count    (nz)
    );

    // One-cycle read latency; garbage when no read was issued.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) rd_data <= rd_en ? mem[addr] : 16'hDEAD;

    int                rd_cyc_q[$];
    logic [ADDR_W-1:0] rd_addr_q[$];
    int                done_q[$];
    logic [ADDR_W-1:0] bidx_q[$];
    logic [DATA_W-1:0] bval_q[$];
    int                bcyc_q[$];
    int                p_rd = 0;
    int                p_bt = 0;
    int                credit_err = 0;
    int                stall_cnt = 0;
    int                stab_err = 0;
    bit                hold_prev = 1'b0;
    bit                chk_credit = 1'b0;
    logic [ADDR_W-1:0] h_idx = '0;
    logic [DATA_W-1:0] h_val = '0;

    // With every word nonzero, reads issued minus beats taken equals buffer plus in-flight.
    always @(negedge clk) begin
        if (rd_en) begin
            rd_cyc_q.push_back(cyc);
            rd_addr_q.push_back(addr);
        end
        if (done) done_q.push_back(cyc);
        if (out_valid && out_ready) begin
            bidx_q.push_back(out_index);
            bval_q.push_back(out_value);
            bcyc_q.push_back(cyc);
        end
        if (hold_prev && (out_valid !== 1'b1 || out_index !== h_idx || out_value !== h_val))
            stab_err++;
        hold_prev = !reset && out_valid && !out_ready;
        h_idx = out_index;
        h_val = out_value;
        if (reset || (finish && !busy)) begin
            p_rd = 0;
            p_bt = 0;
        end else begin
            if (chk_credit) begin
                if (rd_en && (p_rd - p_bt) >= FIFO_D) credit_err++;
                if (!rd_en && busy && p_rd < DEPTH && (p_rd - p_bt) < FIFO_D) credit_err++;
                if (busy && p_rd < DEPTH && (p_rd - p_bt) == FIFO_D) stall_cnt++;
            end
            if (rd_en) p_rd++;
            if (out_valid && out_ready) p_bt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass(output int t0);
        finish = 1'b1;
        t0 = cyc;
        tick();
        finish = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rand_ready);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        n_compared++;
        if (done !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL done_timeout got=%0b exp=1 after %0d cycles", done, n);
        end
    endtask

    function automatic int seq_errors(input int b0, input int n);
        int e;
        e = 0;
        for (int k = 0; k < n; k++) begin
            if (b0 + k >= bidx_q.size()) e++;
            else if (bidx_q[b0+k] != ADDR_W'(k) || bval_q[b0+k] != DATA_W'(k + 1)) e++;
        end
        return e;
    endfunction

    task automatic fill_ramp();
        for (int k = 0; k < DEPTH; k++) mem[k] = DATA_W'(k + 1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        finish = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        n_compared++; if (rd_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_rd_en got=%0b exp=0", rd_en); end
        n_compared++; if (addr !== '0) begin n_mismatched++; $display("[TB] FAIL reset_addr got=%0h exp=0", addr); end
        n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_valid); end
        n_compared++; if (out_index !== '0) begin n_mismatched++; $display("[TB] FAIL reset_out_index got=%0h exp=0", out_index); end
        n_compared++; if (out_value !== '0) begin n_mismatched++; $display("[TB] FAIL reset_out_value got=%0h exp=0", out_value); end
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
        n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done got=%0b exp=0", done); end
        n_compared++; if (nz !== '0) begin n_mismatched++; $display("[TB] FAIL reset_nz_count got=%0d exp=0", nz); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_all_zero();
        int t0, r0, b0, d0, td, seq;
        for (int k = 0; k < DEPTH; k++) mem[k] = '0;
        out_ready = 1'b1;
        r0 = rd_cyc_q.size(); b0 = bidx_q.size(); d0 = done_q.size();
        start_pass(t0);
        wait_done(3000, 1'b0);
        td = cyc;
        n_compared++; if (td != t0 + 1027) begin n_mismatched++; $display("[TB] FAIL zero_done_cycle got=%0d exp=%0d", td - t0, 1027); end
        n_compared++; if (rd_cyc_q.size() - r0 != DEPTH) begin n_mismatched++; $display("[TB] FAIL zero_read_count got=%0d exp=%0d", rd_cyc_q.size() - r0, DEPTH); end
        seq = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r0 + k >= rd_cyc_q.size()) seq++;
            else if (rd_cyc_q[r0+k] != t0 + 1 + k || rd_addr_q[r0+k] != ADDR_W'(k)) seq++;
        end
        n_compared++; if (seq != 0) begin n_mismatched++; $display("[TB] FAIL zero_read_sequence got=%0d bad reads exp=0", seq); end
        n_compared++; if (bidx_q.size() - b0 != 0) begin n_mismatched++; $display("[TB] FAIL zero_beats got=%0d exp=0", bidx_q.size() - b0); end
        n_compared++; if (nz !== 11'd0) begin n_mismatched++; $display("[TB] FAIL zero_nz_count got=%0d exp=0", nz); end
        tick();
        n_compared++; if (done !== 1'b0 || busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL zero_after_done got=done%0b/busy%0b exp=0/0", done, busy); end
        n_compared++; if (done_q.size() - d0 != 1) begin n_mismatched++; $display("[TB] FAIL zero_done_pulses got=%0d exp=1", done_q.size() - d0); end
    endtask

    task automatic test_sparse();
        logic [ADDR_W-1:0] e_idx [3];
        logic [DATA_W-1:0] e_val [3];
        logic [ADDR_W-1:0] g_idx;
        logic [DATA_W-1:0] g_val;
        int t0, b0, d0, td;
        e_idx = '{10'd5, 10'd511, 10'd1023};
        e_val = '{16'h0123, 16'hFFF9, 16'h7FFF};
        for (int k = 0; k < DEPTH; k++) mem[k] = '0;
        for (int i = 0; i < 3; i++) mem[e_idx[i]] = e_val[i];
        out_ready = 1'b1;
        b0 = bidx_q.size(); d0 = done_q.size();
        start_pass(t0);
        wait_done(3000, 1'b0);
        td = cyc;
        n_compared++; if (td != t0 + 1028) begin n_mismatched++; $display("[TB] FAIL sparse_done_cycle got=%0d exp=%0d", td - t0, 1028); end
        n_compared++; if (bidx_q.size() - b0 != 3) begin n_mismatched++; $display("[TB] FAIL sparse_beat_count got=%0d exp=3", bidx_q.size() - b0); end
        for (int i = 0; i < 3; i++) begin
            g_idx = (b0 + i < bidx_q.size()) ? bidx_q[b0+i] : 'x;
            g_val = (b0 + i < bval_q.size()) ? bval_q[b0+i] : 'x;
            n_compared++; if (g_idx !== e_idx[i]) begin n_mismatched++; $display("[TB] FAIL sparse_index%0d got=%0d exp=%0d", i, g_idx, e_idx[i]); end
            n_compared++; if (g_val !== e_val[i]) begin n_mismatched++; $display("[TB] FAIL sparse_value%0d got=%0h exp=%0h", i, g_val, e_val[i]); end
        end
        n_compared++; if (b0 >= bcyc_q.size() || bcyc_q[b0] != t0 + 8) begin n_mismatched++; $display("[TB] FAIL sparse_first_beat_cycle got=%0d exp=%0d", (b0 < bcyc_q.size()) ? bcyc_q[b0] - t0 : -1, 8); end
        n_compared++; if (nz !== 11'd3) begin n_mismatched++; $display("[TB] FAIL sparse_nz_count got=%0d exp=3", nz); end
        tick();
        n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL sparse_done_width got=%0b exp=0", done); end
        n_compared++; if (done_q.size() - d0 != 1) begin n_mismatched++; $display("[TB] FAIL sparse_done_pulses got=%0d exp=1", done_q.size() - d0); end
    endtask

    task automatic test_backpressure();
        int t0, r0, b0, d0, c0, s0, e0, seq;
        fill_ramp();
        out_ready = 1'b0;
        r0 = rd_cyc_q.size(); b0 = bidx_q.size(); d0 = done_q.size();
        c0 = credit_err; s0 = stall_cnt; e0 = stab_err;
        chk_credit = 1'b1;
        start_pass(t0);
        repeat (49) tick();
        n_compared++; if (rd_cyc_q.size() - r0 != FIFO_D) begin n_mismatched++; $display("[TB] FAIL bp_reads_while_stalled got=%0d exp=%0d", rd_cyc_q.size() - r0, FIFO_D); end
        n_compared++; if (out_valid !== 1'b1 || out_index !== 10'd0 || out_value !== 16'd1) begin n_mismatched++; $display("[TB] FAIL bp_held_head got=v%0b/%0d/%0h exp=v1/0/1", out_valid, out_index, out_value); end
        wait_done(12000, 1'b1);
        out_ready = 1'b1;
        chk_credit = 1'b0;
        n_compared++; if (bidx_q.size() - b0 != DEPTH) begin n_mismatched++; $display("[TB] FAIL bp_beat_count got=%0d exp=%0d", bidx_q.size() - b0, DEPTH); end
        seq = seq_errors(b0, DEPTH);
        n_compared++; if (seq != 0) begin n_mismatched++; $display("[TB] FAIL bp_beat_sequence got=%0d bad beats exp=0", seq); end
        n_compared++; if (nz !== 11'd1024) begin n_mismatched++; $display("[TB] FAIL bp_nz_count got=%0d exp=1024", nz); end
        n_compared++; if (credit_err - c0 != 0) begin n_mismatched++; $display("[TB] FAIL bp_credit got=%0d violations exp=0", credit_err - c0); end
        n_compared++; if (stall_cnt - s0 <= 0) begin n_mismatched++; $display("[TB] FAIL bp_stall_seen got=%0d stall cycles exp>0", stall_cnt - s0); end
        n_compared++; if (stab_err - e0 != 0) begin n_mismatched++; $display("[TB] FAIL bp_hold_stable got=%0d changes exp=0", stab_err - e0); end
        tick();
        n_compared++; if (done_q.size() - d0 != 1) begin n_mismatched++; $display("[TB] FAIL bp_done_pulses got=%0d exp=1", done_q.size() - d0); end
    endtask

    task automatic test_back_to_back();
        int t0, r0, b0, d0, td, seq;
        fill_ramp();
        out_ready = 1'b1;
        r0 = rd_cyc_q.size(); b0 = bidx_q.size(); d0 = done_q.size();
        start_pass(t0);
        n_compared++; if (nz !== 11'd0) begin n_mismatched++; $display("[TB] FAIL b2b_nz_restart got=%0d exp=0", nz); end
        n_compared++; if (busy !== 1'b1 || rd_en !== 1'b1 || addr !== 10'd0) begin n_mismatched++; $display("[TB] FAIL b2b_first_read got=b%0b/r%0b/a%0d exp=1/1/0", busy, rd_en, addr); end
        repeat (99) tick();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        wait_done(3000, 1'b0);
        td = cyc;
        n_compared++; if (td != t0 + 1028) begin n_mismatched++; $display("[TB] FAIL b2b_done_cycle got=%0d exp=%0d", td - t0, 1028); end
        n_compared++; if (bidx_q.size() - b0 != DEPTH) begin n_mismatched++; $display("[TB] FAIL b2b_beat_count got=%0d exp=%0d", bidx_q.size() - b0, DEPTH); end
        seq = seq_errors(b0, DEPTH);
        n_compared++; if (seq != 0) begin n_mismatched++; $display("[TB] FAIL b2b_beat_sequence got=%0d bad beats exp=0", seq); end
        n_compared++; if (b0 >= bcyc_q.size() || bcyc_q[b0] != t0 + 3) begin n_mismatched++; $display("[TB] FAIL b2b_first_beat_cycle got=%0d exp=3", (b0 < bcyc_q.size()) ? bcyc_q[b0] - t0 : -1); end
        n_compared++; if (bcyc_q.size() == 0 || bcyc_q[bcyc_q.size()-1] != t0 + 1026) begin n_mismatched++; $display("[TB] FAIL b2b_last_beat_cycle got=%0d exp=1026", (bcyc_q.size() > 0) ? bcyc_q[bcyc_q.size()-1] - t0 : -1); end
        n_compared++; if (nz !== 11'd1024) begin n_mismatched++; $display("[TB] FAIL b2b_nz_count got=%0d exp=1024", nz); end
        finish = 1'b1;
        tick();
        finish = 1'b0;
        n_compared++; if (busy !== 1'b0 || done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_pulse_in_done got=b%0b/d%0b exp=0/0", busy, done); end
        repeat (3) tick();
        n_compared++; if (busy !== 1'b0 || rd_cyc_q.size() - r0 != DEPTH) begin n_mismatched++; $display("[TB] FAIL b2b_single_pass got=b%0b/reads%0d exp=0/%0d", busy, rd_cyc_q.size() - r0, DEPTH); end
        n_compared++; if (done_q.size() - d0 != 1) begin n_mismatched++; $display("[TB] FAIL b2b_done_pulses got=%0d exp=1", done_q.size() - d0); end
    endtask

    task automatic test_reset_mid_scan();
        int t0, t1, d0, b1, td, seq;
        fill_ramp();
        out_ready = 1'b1;
        d0 = done_q.size();
        start_pass(t0);
        repeat (489) tick();
        out_ready = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        n_compared++; if (rd_en !== 1'b0 || addr !== '0) begin n_mismatched++; $display("[TB] FAIL mid_reset_read got=r%0b/a%0d exp=0/0", rd_en, addr); end
        n_compared++; if (out_valid !== 1'b0 || out_index !== '0 || out_value !== '0) begin n_mismatched++; $display("[TB] FAIL mid_reset_out got=v%0b/%0d/%0h exp=0/0/0", out_valid, out_index, out_value); end
        n_compared++; if (busy !== 1'b0 || done !== 1'b0 || nz !== '0) begin n_mismatched++; $display("[TB] FAIL mid_reset_status got=b%0b/d%0b/n%0d exp=0/0/0", busy, done, nz); end
        reset = 1'b0;
        repeat (5) tick();
        n_compared++; if (busy !== 1'b0 || out_valid !== 1'b0 || done_q.size() != d0) begin n_mismatched++; $display("[TB] FAIL mid_reset_idle got=b%0b/v%0b/dones%0d exp=0/0/0", busy, out_valid, done_q.size() - d0); end
        out_ready = 1'b1;
        b1 = bidx_q.size();
        start_pass(t1);
        wait_done(3000, 1'b0);
        td = cyc;
        n_compared++; if (td != t1 + 1028) begin n_mismatched++; $display("[TB] FAIL repass_done_cycle got=%0d exp=1028", td - t1); end
        n_compared++; if (bidx_q.size() - b1 != DEPTH) begin n_mismatched++; $display("[TB] FAIL repass_beat_count got=%0d exp=%0d", bidx_q.size() - b1, DEPTH); end
        seq = seq_errors(b1, DEPTH);
        n_compared++; if (seq != 0) begin n_mismatched++; $display("[TB] FAIL repass_beat_sequence got=%0d bad beats exp=0", seq); end
        n_compared++; if (nz !== 11'd1024) begin n_mismatched++; $display("[TB] FAIL repass_nz_count got=%0d exp=1024", nz); end
        tick();
    endtask

    initial begin
        $display("[TB] omp_result_reader bench start");
        test_reset();
        test_all_zero();
        test_sparse();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/omp_result_reader.md
# omp_result_reader

Reads the 1024-entry sparse coefficient memory written by `Block_1024` once it raises `finish_flag`. Scans all addresses in order and emits only the nonzero coefficients as an (index, value) stream with valid/ready handshake. Signals completion with a one-cycle `done` pulse and a held nonzero count. Sits between the OMP reconstruction core and the result sink (bench dump or host link).

## Interface
- `DEPTH`, 1024, coefficient memory entries.
- `ADDR_W`, 10, log2(DEPTH).
- `DATA_W`, 16, signed two's-complement coefficient width.
- `FIFO_D`, 4, output buffer depth (power of 2, ≥2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `finish_flag`  in  1  one-cycle start pulse from `Block_1024`.
- `mem_rd_en`  out  1  memory read strobe.
- `mem_addr`  out  ADDR_W  read address.
- `mem_rd_data`  in  DATA_W  read data, valid exactly 1 cycle after `mem_rd_en`.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  sink accepts beat.
- `out_index`  out  ADDR_W  coefficient address.
- `out_value`  out  DATA_W  coefficient value, never 0.
- `busy`  out  1  high from SCAN entry until DONE.
- `done`  out  1  one-cycle completion pulse.
- `nz_count`  out  ADDR_W+1  nonzero beats emitted in current/last pass.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: `finish_flag`=1 → SCAN; address counter ← 0, `nz_count` ← 0, FIFO empty.
- SCAN: issue read (`mem_rd_en`=1, `mem_addr`=counter) when fifo_count + inflight < FIFO_D; counter increments per issue. Cycle issuing address DEPTH-1 → DRAIN.
- Read return: address tagged in a 1-deep pipeline register; if `mem_rd_data` ≠ 0, push {addr, data} into FIFO; zero values dropped. Credit rule guarantees the FIFO never overflows.
- Handshake: beat transfers when `out_valid`&&`out_ready`. `out_valid` never drops, and `out_index`/`out_value` never change, until transfer. Indices strictly increasing within a pass. `nz_count` increments per transfer.
- DRAIN: inflight=0 and FIFO empty → DONE.
- DONE: `done`=1 for one cycle → IDLE. `busy` low in IDLE only.
- `finish_flag` outside IDLE ignored; in DONE also ignored (needs new pulse in IDLE).
- `nz_count` holds its value after DONE until next start; max value DEPTH (all nonzero).
- Reset values: `mem_rd_en`=0, `mem_addr`=0, `out_valid`=0, `out_index`=0, `out_value`=0, `busy`=0, `done`=0, `nz_count`=0, state IDLE, FIFO empty, inflight=0.
- Reset mid-pass: aborts at next edge; no `done`, pending FIFO contents discarded.

## Timing
- `finish_flag` in cycle t → SCAN at t+1, first read (addr 0) at t+1, data at t+2, earliest `out_valid` t+3.
- With `out_ready`=1: one read per cycle, addresses 0..1023 at t+1..t+1024, DRAIN from t+1025.
- All-zero memory: `done` at t+1027. All-nonzero, `out_ready`=1: beats t+3..t+1026, `done` at t+1028.
- Pop and push in same cycle on a full FIFO permitted; count unchanged.
- Output registered from FIFO head; no combinational path `out_ready`→`out_valid`. `out_ready`→`mem_rd_en` combinational path permitted through credit check.

## Structure
- Package `omp_pkg`: DEPTH, ADDR_W, DATA_W constants, state enum `omp_rd_state_t`, beat struct {index, value}.
- Sub-module `omp_sync_fifo` (parameterised width/depth, registered head, count output); the FSM, credit counter, and tag register live in top.

## Test plan
- All-zero memory, pulse at t → `mem_rd_en` high t+1..t+1024, no `out_valid`, `done` at t+1027, `nz_count`=0.
- Nonzero at 5 (0x0123), 511 (0xFFF9), 1023 (0x7FFF), `out_ready`=1 → exactly three beats in that order, values exact, `nz_count`=3, `done` one cycle.
- All-nonzero (value=addr+1), `out_ready` low for 50 cycles then random 50% → 1024 beats, no loss/duplication, `mem_rd_en` stalls once fifo+inflight=4, `nz_count`=1024.
- `finish_flag` re-pulsed at t+100 during SCAN → ignored (single pass). New pulse in IDLE after `done` → fresh pass, `nz_count` restarts at 0.
- `reset` asserted at t+500 mid-scan → next cycle all outputs at reset values, no `done`. New pulse → full correct pass from address 0.
